// File: rtl/rtc_bus_responder.sv
// RTC port-bus responder: runs timed address/data cycles on the multiplexed RTC bus.
// Optional completion interrupt is built only when RTC_IRQ_EN is defined.
module rtc_bus_responder #(
    parameter int unsigned T_PHASE = 10,
    parameter int unsigned T_GAP   = 4
) (
    input  logic       clk,
    input  logic       kcpsm6_reset,
    input  logic       actRTC,
    input  logic       writestrobe,
    input  logic       read_strobe,
    input  logic [7:0] dir,
    input  logic [7:0] out_port,
    output logic [7:0] in_portRTC,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic       busy,
    output logic       overrun,
    output logic       rtc_cs_n,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic       rtc_ad_sel,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_in
);

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD
    } state_t;

    localparam logic [7:0] PH_LD  = 8'(T_PHASE - 1);
    localparam logic [7:0] GAP_LD = 8'(T_GAP - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       op_wr;
    logic [7:0] rdata;
    logic       ovr;

    logic req;
    logic accept;
    logic drop;
    logic cnt_zero;
    logic capture;

    assign req      = actRTC & (writestrobe | read_strobe);
    assign accept   = req & (state == IDLE);
    assign drop     = req & (state != IDLE);
    assign cnt_zero = (cnt == 8'd0);
    assign capture  = (state == D_STB) & cnt_zero & ~op_wr;

    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Each timed phase reloads the counter on entry and leaves when it hits 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = A_SET;
                end
            end
            A_SET: begin
                state_nxt = A_STB;
                cnt_nxt   = PH_LD;
            end
            A_STB: begin
                if (cnt_zero) begin
                    state_nxt = A_HLD;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            A_HLD: begin
                if (cnt_zero) begin
                    state_nxt = D_SET;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            D_SET: begin
                state_nxt = D_STB;
                cnt_nxt   = PH_LD;
            end
            D_STB: begin
                if (cnt_zero) begin
                    state_nxt = D_HLD;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            D_HLD: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        rtc_cs_n   = 1'b1;
        rtc_wr_n   = 1'b1;
        rtc_rd_n   = 1'b1;
        rtc_ad_sel = 1'b1;
        rtc_ad_out = 8'd0;
        rtc_ad_oe  = 1'b0;
        unique case (state)
            A_SET, A_STB, A_HLD: begin
                rtc_cs_n   = 1'b0;
                rtc_ad_oe  = 1'b1;
                rtc_ad_out = addr;
                rtc_wr_n   = (state != A_STB);
            end
            D_SET, D_STB, D_HLD: begin
                rtc_cs_n   = 1'b0;
                rtc_ad_sel = 1'b0;
                if (op_wr) begin
                    rtc_ad_oe  = 1'b1;
                    rtc_ad_out = wdata;
                    rtc_wr_n   = (state != D_STB);
                end else begin
                    rtc_rd_n = (state != D_STB);
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            addr  <= 8'd0;
            wdata <= 8'd0;
            op_wr <= 1'b0;
        end else if (accept) begin
            addr  <= dir;
            wdata <= out_port;
            op_wr <= writestrobe;
        end
    end

    // A dropped request flags the firmware; the next accepted one clears it.
    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            ovr <= 1'b0;
        end else if (accept) begin
            ovr <= 1'b0;
        end else if (drop) begin
            ovr <= 1'b1;
        end
    end

    assign overrun = ovr;

    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            rdata <= 8'd0;
        end else if (capture) begin
            rdata <= rtc_ad_in;
        end
    end

    assign in_portRTC = rdata;

`ifdef RTC_IRQ_EN
    logic irq;
    logic done;

    assign done = (state == D_HLD) & cnt_zero;

    // Completion beats a coincident acknowledge.
    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (interrupt_ack) begin
            irq <= 1'b0;
        end
    end

    assign interrupt = irq;
`else
    logic ack_unused;

    assign ack_unused = interrupt_ack;
    assign interrupt  = 1'b0;
`endif

endmodule
